// File: rtl/sprite_draw_scheduler_pkg.sv
// Shared types and constants for the sprite draw scheduler: FSM states,
// the transparent colour key and the round-robin pointer advance helper.
package sprite_draw_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCAN,
    ST_FLUSH,
    ST_DONE
  } sched_state_t;

  localparam logic [2:0] TRANSPARENT_COLOUR = 3'b000;

  function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sprite_draw_scheduler_rr_arbiter.sv
// Round-robin arbiter: first set request at or above ptr (wrapping) wins;
// returns one-hot grant, binary index and a valid flag.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  int unsigned w_j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    w_j   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_j = (32'(ptr) + k) % N;
      if (!valid && req[w_j]) begin
        valid    = 1'b1;
        idx      = IDX_W'(w_j);
        gnt[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Round-robin sprite rasteriser sharing one VGA plot port between NUM_REQ requesters.
// Optional build macro SPRITE_SCHED_TRANSPARENT_EN suppresses plots of the transparent colour.
module sprite_draw_scheduler
  import sprite_draw_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 8,
  parameter int unsigned SZ_W     = 6,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned COLOUR_W = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*X_W-1:0]     req_x,
  input  logic [NUM_REQ*Y_W-1:0]     req_y,
  input  logic [NUM_REQ*SZ_W-1:0]    req_w,
  input  logic [NUM_REQ*SZ_W-1:0]    req_h,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_base,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [COLOUR_W-1:0]        rom_data,
  output logic [X_W-1:0]             vga_x,
  output logic [Y_W-1:0]             vga_y,
  output logic [COLOUR_W-1:0]        vga_colour,
  output logic                       vga_plot,
  output logic                       busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_t        r_state, w_next;
  logic [IDX_W-1:0]    r_idx, r_ptr, w_arb_idx;
  logic [NUM_REQ-1:0]  r_onehot, w_arb_gnt;
  logic                w_arb_valid;
  logic [X_W-1:0]      r_x0, r_vx, w_sel_x;
  logic [Y_W-1:0]      r_y0, r_vy, w_sel_y;
  logic [SZ_W-1:0]     r_w, r_h, r_col, r_row, w_sel_w, w_sel_h;
  logic [ADDR_W-1:0]   r_addr, w_sel_base;
  logic                r_plot, w_col_end, w_last;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req   (req),
    .ptr   (r_ptr),
    .gnt   (w_arb_gnt),
    .idx   (w_arb_idx),
    .valid (w_arb_valid)
  );

  assign w_sel_x    = req_x[r_idx*X_W +: X_W];
  assign w_sel_y    = req_y[r_idx*Y_W +: Y_W];
  assign w_sel_w    = req_w[r_idx*SZ_W +: SZ_W];
  assign w_sel_h    = req_h[r_idx*SZ_W +: SZ_W];
  assign w_sel_base = req_base[r_idx*ADDR_W +: ADDR_W];

  assign w_col_end = (r_col == r_w - SZ_W'(1));
  assign w_last    = w_col_end && (r_row == r_h - SZ_W'(1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_arb_valid) w_next = ST_LOAD;
      ST_LOAD:  w_next = ((w_sel_w == '0) || (w_sel_h == '0)) ? ST_DONE : ST_SCAN;
      ST_SCAN:  if (w_last) w_next = ST_FLUSH;
      ST_FLUSH: w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // The plot registers trail the ROM address by one cycle so they line up with rom_data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx    <= '0;
      r_ptr    <= '0;
      r_onehot <= '0;
      r_x0     <= '0;
      r_y0     <= '0;
      r_w      <= '0;
      r_h      <= '0;
      r_col    <= '0;
      r_row    <= '0;
      r_addr   <= '0;
      r_vx     <= '0;
      r_vy     <= '0;
      r_plot   <= 1'b0;
    end else begin
      r_plot <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_arb_valid) begin
            r_idx    <= w_arb_idx;
            r_onehot <= w_arb_gnt;
          end
        end
        ST_LOAD: begin
          r_x0   <= w_sel_x;
          r_y0   <= w_sel_y;
          r_w    <= w_sel_w;
          r_h    <= w_sel_h;
          r_addr <= w_sel_base;
          r_col  <= '0;
          r_row  <= '0;
        end
        ST_SCAN: begin
          r_plot <= 1'b1;
          r_vx   <= r_x0 + X_W'(r_col);
          r_vy   <= r_y0 + Y_W'(r_row);
          r_addr <= r_addr + ADDR_W'(1);
          if (w_col_end) begin
            r_col <= '0;
            r_row <= r_row + SZ_W'(1);
          end else begin
            r_col <= r_col + SZ_W'(1);
          end
        end
        ST_DONE: r_ptr <= IDX_W'(next_ptr(32'(r_idx), NUM_REQ));
        default: ;
      endcase
    end
  end

  assign grant      = ((r_state == ST_LOAD) || (r_state == ST_SCAN) || (r_state == ST_FLUSH))
                      ? r_onehot : '0;
  assign done       = (r_state == ST_DONE) ? r_onehot : '0;
  assign busy       = (r_state != ST_IDLE);
  assign rom_addr   = r_addr;
  assign vga_x      = r_vx;
  assign vga_y      = r_vy;
  assign vga_colour = rom_data;

`ifdef SPRITE_SCHED_TRANSPARENT_EN
  assign vga_plot = r_plot && (rom_data != COLOUR_W'(TRANSPARENT_COLOUR));
`else
  assign vga_plot = r_plot;
`endif

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Self-checking bench for sprite_draw_scheduler: per-cycle schedule model plus literal pins.
module tb_sprite_draw_scheduler;

  localparam int N = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N*8-1:0]   req_x = '0;
  logic [N*8-1:0]   req_y = '0;
  logic [N*6-1:0]   req_w = '0;
  logic [N*6-1:0]   req_h = '0;
  logic [N*12-1:0]  req_base = '0;
  logic [N-1:0]     grant, done;
  logic [11:0]      rom_addr;
  logic [2:0]       rom_data = '0;
  logic [7:0]       vga_x, vga_y;
  logic [2:0]       vga_colour;
  logic             vga_plot, busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_total = 0;
  int q_px[$], q_py[$], q_dix[$], q_dcyc[$];

  sprite_draw_scheduler #(
    .NUM_REQ(4), .X_W(8), .Y_W(8), .SZ_W(6), .ADDR_W(12), .COLOUR_W(3)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
    .req_w(req_w), .req_h(req_h), .req_base(req_base), .grant(grant), .done(done),
    .rom_addr(rom_addr), .rom_data(rom_data), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [2:0] rom_f(input logic [11:0] a);
    return a[0] ? 3'b101 : 3'b000;
  endfunction

  always @(posedge clock) rom_data <= rom_f(rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Schedule model: t counts cycles since the idle cycle that saw the request.
  logic        m_active = 1'b0;
  int          m_ptr = 0, m_g = 0, m_t = 0, m_n = 0, m_end = 0;
  int          m_w = 0, m_h = 0;
  logic [7:0]  m_x0, m_y0;
  logic [11:0] m_base;

  always @(negedge clock) begin : compare
    logic [N-1:0] e_gnt, e_done, oh;
    logic         e_busy, found, e_plot;
    int           k, j;
    logic [11:0]  pa;
    if (reset) begin
      m_active = 1'b0;
      m_ptr    = 0;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_plot", 32'(vga_plot), 0);
      chk("rst_addr", 32'(rom_addr), 0);
    end else begin
      e_busy = 1'b0; e_gnt = '0; e_done = '0; found = 1'b0;
      oh = '0;
      if (!m_active) begin
        if (req != '0) begin
          for (int i = 0; i < N; i++) begin
            j = (m_ptr + i) % N;
            if (!found && req[j]) begin found = 1'b1; m_g = j; end
          end
          m_active = 1'b1;
          m_t = 0;
        end
      end else begin
        m_t++;
        if (m_t == 1) begin
          m_x0   = req_x[m_g*8 +: 8];
          m_y0   = req_y[m_g*8 +: 8];
          m_w    = int'(req_w[m_g*6 +: 6]);
          m_h    = int'(req_h[m_g*6 +: 6]);
          m_base = req_base[m_g*12 +: 12];
          m_n    = m_w * m_h;
          m_end  = (m_n == 0) ? 2 : m_n + 3;
        end
        oh[m_g] = 1'b1;
        e_busy = 1'b1;
        if (m_t < m_end)  e_gnt  = oh;
        if (m_t == m_end) e_done = oh;
        if (m_t >= 2 && m_t <= m_n + 1)
          chk("rom_addr", 32'(rom_addr), 32'(m_base + 12'(m_t - 2)));
        if (m_t >= 3 && m_t <= m_n + 2) begin
          k  = m_t - 3;
          pa = m_base + 12'(k);
`ifdef SPRITE_SCHED_TRANSPARENT_EN
          e_plot = (rom_f(pa) != 3'b000);
`else
          e_plot = 1'b1;
`endif
          chk("pix_plot", 32'(vga_plot), 32'(e_plot));
          chk("pix_x", 32'(vga_x), 32'(8'(m_x0 + 8'(k % m_w))));
          chk("pix_y", 32'(vga_y), 32'(8'(m_y0 + 8'(k / m_w))));
          chk("pix_colour", 32'(vga_colour), 32'(rom_f(pa)));
        end else begin
          chk("noplot", 32'(vga_plot), 0);
        end
        if (m_t == m_end) begin
          m_active = 1'b0;
          m_ptr = (m_g + 1) % N;
        end
      end
      if (!e_busy) chk("idle_plot", 32'(vga_plot), 0);
      chk("busy", 32'(busy), 32'(e_busy));
      chk("grant", 32'(grant), 32'(e_gnt));
      chk("done", 32'(done), 32'(e_done));
      if (vga_plot) begin q_px.push_back(int'(vga_x)); q_py.push_back(int'(vga_y)); end
      if (done != '0) begin
        for (int i = 0; i < N; i++) if (done[i]) q_dix.push_back(i);
        q_dcyc.push_back(cyc);
        done_total++;
      end
    end
  end

  task automatic clear_logs();
    q_px.delete(); q_py.delete(); q_dix.delete(); q_dcyc.delete();
  endtask

  task automatic set_geom(input int idx, input int x, input int y, input int w,
                          input int h, input int base);
    req_x[idx*8 +: 8]     = 8'(x);
    req_y[idx*8 +: 8]     = 8'(y);
    req_w[idx*6 +: 6]     = 6'(w);
    req_h[idx*6 +: 6]     = 6'(h);
    req_base[idx*12 +: 12] = 12'(base);
  endtask

  task automatic issue(input int idx, input int x, input int y, input int w,
                       input int h, input int base, output int c0);
    @(posedge clock); #1;
    clear_logs();
    set_geom(idx, x, y, w, h, base);
    req[idx] = 1'b1;
    c0 = cyc;
  endtask

  task automatic wait_total(input int target, input int limit, input string name);
    int n = 0;
    while (done_total < target && n < limit) begin
      @(posedge clock); #1;
      n++;
    end
    chk({name, "_timeout"}, 32'(done_total >= target), 1);
  endtask

  int c0, base_total, exp_px[$];

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // All four requesting from reset: round-robin order 0,1,2,3,0.
    @(posedge clock); #1;
    clear_logs();
    for (int i = 0; i < N; i++) set_geom(i, i * 10, i, 1, 1, i * 16);
    base_total = done_total;
    req = 4'b1111;
    wait_total(base_total + 5, 100, "rr");
    req = '0;
    chk("rr_count", 32'(q_dix.size()), 5);
    if (q_dix.size() >= 5) begin
      chk("rr_0", 32'(q_dix[0]), 0); chk("rr_1", 32'(q_dix[1]), 1);
      chk("rr_2", 32'(q_dix[2]), 2); chk("rr_3", 32'(q_dix[3]), 3);
      chk("rr_4", 32'(q_dix[4]), 0);
    end

    // Single 3x2 draw; geometry change after LOAD must be ignored.
    base_total = done_total;
    issue(0, 10, 20, 3, 2, 100, c0);
    repeat (4) @(posedge clock);
    #1 req_x[7:0] = 8'd99;
    wait_total(base_total + 1, 50, "t1");
    req[0] = 1'b0;
    chk("t1_nplots", 32'(q_px.size()), 6);
    if (q_dcyc.size() > 0) chk("t1_done_cyc", 32'(q_dcyc[0] - c0), 9);
    exp_px = '{10, 11, 12, 10, 11, 12};
    if (q_px.size() == 6)
      for (int i = 0; i < 6; i++) begin
        chk("t1_x", 32'(q_px[i]), 32'(exp_px[i]));
        chk("t1_y", 32'(q_py[i]), 32'((i < 3) ? 20 : 21));
      end

    // Zero-width rectangle: no plots, done straight after LOAD.
    base_total = done_total;
    issue(2, 5, 5, 0, 5, 7, c0);
    wait_total(base_total + 1, 20, "t3");
    req[2] = 1'b0;
    chk("t3_nplots", 32'(q_px.size()), 0);
    if (q_dcyc.size() > 0) chk("t3_done_cyc", 32'(q_dcyc[0] - c0), 2);
    if (q_dix.size() > 0) chk("t3_done_idx", 32'(q_dix[0]), 2);

    // Reset in the middle of a 27x48 draw, then redraw from base.
    issue(1, 5, 6, 27, 48, 500, c0);
    repeat (40) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("t4_busy0", 32'(busy), 0);
    chk("t4_grant0", 32'(grant), 0);
    chk("t4_plot0", 32'(vga_plot), 0);
    chk("t4_addr0", 32'(rom_addr), 0);
    chk("t4_x0", 32'(vga_x), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    clear_logs();
    c0 = cyc;
    base_total = done_total;
    repeat (2) @(posedge clock);
    #1 chk("t4_first_addr", 32'(rom_addr), 500);
    wait_total(base_total + 1, 1400, "t4");
    req[1] = 1'b0;
    chk("t4_ndone", 32'(q_dix.size()), 1);
    if (q_dcyc.size() > 0) chk("t4_done_cyc", 32'(q_dcyc[0] - c0), 27 * 48 + 3);
    chk("t4_nplots", 32'(q_px.size()), 27 * 48);

    // x wraps mod 256; request dropped mid-draw still completes.
    base_total = done_total;
    issue(3, 250, 7, 10, 1, 0, c0);
    repeat (4) @(posedge clock);
    #1 req[3] = 1'b0;
    wait_total(base_total + 1, 50, "t5");
    exp_px = '{250, 251, 252, 253, 254, 255, 0, 1, 2, 3};
    chk("t5_nplots", 32'(q_px.size()), 10);
    if (q_px.size() == 10)
      for (int i = 0; i < 10; i++) chk("t5_x", 32'(q_px[i]), 32'(exp_px[i]));
    if (q_dix.size() > 0) chk("t5_done_idx", 32'(q_dix[0]), 3);

    // Alternating 000/101 sprite: transparent build plots only the 101 pixels.
    base_total = done_total;
    issue(0, 0, 0, 4, 2, 200, c0);
    wait_total(base_total + 1, 50, "t6");
    req[0] = 1'b0;
    if (q_dcyc.size() > 0) chk("t6_done_cyc", 32'(q_dcyc[0] - c0), 11);
`ifdef SPRITE_SCHED_TRANSPARENT_EN
    chk("t6_nplots", 32'(q_px.size()), 4);
    if (q_px.size() == 4) begin
      chk("t6_x0", 32'(q_px[0]), 1); chk("t6_x1", 32'(q_px[1]), 3);
    end
`else
    chk("t6_nplots", 32'(q_px.size()), 8);
`endif

    repeat (3) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
